// File: rtl/reg_bank_encap.sv
// ARMv4 general register file R0-R15 with A/B/C read ports, write-index muxing,
// PC increment and the load/store-multiple register counter.
module reg_bank_encap #(
   parameter logic [31:0] START_ADDRESS = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        LATCH_REG,
   input  logic        IR_RD_MUX,
   input  logic        LSM_RD_MUX,
   input  logic [1:0]  RD_MUX,
   input  logic        PC_MUX,
   input  logic        DATA_MUX,
   input  logic        REG_GATE_B,
   input  logic        REG_GATE_C,
   input  logic [31:0] IR,
   input  logic [31:0] ALU_BUS,
   output logic [3:0]  REG_COUNTER,
   output logic [31:0] A_BUS,
   inout  wire  [31:0] B_BUS,
   output wire  [31:0] C_BUS,
   output logic [31:0] ST,
   output logic [31:0] PC
);

   localparam logic [3:0] IdxSp   = 4'd13;
   localparam logic [3:0] IdxLink = 4'd14;
   localparam logic [3:0] IdxPc   = 4'd15;

   logic [31:0] regs_q [16];
   logic [15:0] done_q, done_d;
   logic [31:0] ir_q;

   logic [15:0] pending;
   logic [3:0]  lsm_idx;
   logic        lsm_any;
   logic        lsm_adv;
   logic        ir_changed;

   logic [3:0]  b_idx;
   logic [3:0]  w_idx;
   logic [31:0] b_rd;
   logic [31:0] wdata;

   // Lowest register still to be transferred by the current LSM instruction.
   always_comb begin
      pending = IR[15:0] & ~done_q;
      lsm_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pending[i]) lsm_idx = 4'(i);
      end
   end

   assign lsm_any     = |pending;
   assign REG_COUNTER = lsm_idx;

   // LSM advance: reading via the counter or writing to the counter register both
   // consume the current entry, but only once per edge.
   always_comb begin
      ir_changed = (IR != ir_q);
      lsm_adv    = lsm_any & (LSM_RD_MUX | (LATCH_REG & (RD_MUX == 2'b11)));
      done_d     = done_q;
      if (lsm_adv) done_d[lsm_idx] = 1'b1;
      // A new instruction restarts the walk and discards any same-edge advance.
      if (ir_changed) done_d = '0;
   end

   // B read index: LSM counter overrides the Rm/Rd selection.
   always_comb begin
      if (LSM_RD_MUX) begin
         b_idx = lsm_idx;
      end else if (IR_RD_MUX) begin
         b_idx = IR[15:12];
      end else begin
         b_idx = IR[3:0];
      end
   end

   // Write index selection.
   always_comb begin
      unique case (RD_MUX)
         2'b00:   w_idx = IR[15:12];
         2'b01:   w_idx = IR[19:16];
         2'b10:   w_idx = IdxLink;
         default: w_idx = lsm_idx;
      endcase
   end

   // Read ports are straight reads of the array; no write bypass, no PC+8.
   always_comb begin
      A_BUS = regs_q[IR[19:16]];
      b_rd  = regs_q[b_idx];
      ST    = regs_q[IdxSp];
      PC    = regs_q[IdxPc];
   end

   assign B_BUS = REG_GATE_B ? b_rd : 'z;
   assign C_BUS = REG_GATE_C ? regs_q[IR[11:8]] : 'z;

   // With DATA_MUX=1 the write data comes from whoever drives the shared B bus.
   assign wdata = DATA_MUX ? B_BUS : ALU_BUS;

   // Register array update; an explicit write to R15 takes priority over the increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= '0;
         end
         regs_q[IdxPc] <= START_ADDRESS;
      end else begin
         if (PC_MUX) regs_q[IdxPc] <= regs_q[IdxPc] + 32'd4;
         if (LATCH_REG) regs_q[w_idx] <= wdata;
      end
   end

   // LSM done-mask and instruction shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= '0;
         ir_q   <= IR;
      end else begin
         done_q <= done_d;
         ir_q   <= IR;
      end
   end

endmodule

// File: tb/tb_reg_bank_encap.sv
// Self-checking bench for reg_bank_encap: directed vector table, a few hand
// sequences, then randomized traffic against a set/queue based reference model.
module tb_reg_bank_encap;

   localparam logic [31:0] START = 32'h0000_0000;

   // Control word: {rst, latch, ir_rd, lsm_rd, rd_mux[1:0], pc_mux, data_mux, gate_b, gate_c}
   localparam logic [9:0] C_NONE  = 10'h000;
   localparam logic [9:0] C_RST   = 10'h200;
   localparam logic [9:0] C_LATCH = 10'h100;
   localparam logic [9:0] C_IRRD  = 10'h080;
   localparam logic [9:0] C_LSM   = 10'h040;
   localparam logic [9:0] C_RD01  = 10'h010;
   localparam logic [9:0] C_RD10  = 10'h020;
   localparam logic [9:0] C_RD11  = 10'h030;
   localparam logic [9:0] C_PC    = 10'h008;
   localparam logic [9:0] C_DATA  = 10'h004;
   localparam logic [9:0] C_GB    = 10'h002;
   localparam logic [9:0] C_GC    = 10'h001;

   localparam logic [5:0] M_A   = 6'h01;
   localparam logic [5:0] M_PC  = 6'h02;
   localparam logic [5:0] M_ST  = 6'h04;
   localparam logic [5:0] M_CNT = 6'h08;
   localparam logic [5:0] M_B   = 6'h10;
   localparam logic [5:0] M_C   = 6'h20;

   typedef struct {
      string       name;
      logic [9:0]  ctl;
      logic [31:0] ir;
      logic [31:0] alu;
      logic        drv;
      logic [31:0] bval;
      logic [5:0]  mask;
      logic [31:0] ea;
      logic [31:0] epc;
      logic [31:0] est;
      logic [3:0]  ecnt;
      logic [31:0] eb;
      logic [31:0] ec;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        latch_reg;
   logic        ir_rd_mux;
   logic        lsm_rd_mux;
   logic [1:0]  rd_mux;
   logic        pc_mux;
   logic        data_mux;
   logic        reg_gate_b;
   logic        reg_gate_c;
   logic [31:0] ir;
   logic [31:0] alu_bus;
   logic [3:0]  reg_counter;
   logic [31:0] a_bus;
   wire  [31:0] b_bus;
   wire  [31:0] c_bus;
   logic [31:0] st;
   logic [31:0] pc;

   logic        drv_b;
   logic [31:0] b_val;
   assign b_bus = drv_b ? b_val : 'z;

   int checks;
   int errors;

   vec_t vecs[$];

   // Reference model state
   logic [31:0] m_r [16];
   int          m_done[$];
   logic [31:0] m_last_ir;

   reg_bank_encap #(
      .START_ADDRESS (START)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .LATCH_REG   (latch_reg),
      .IR_RD_MUX   (ir_rd_mux),
      .LSM_RD_MUX  (lsm_rd_mux),
      .RD_MUX      (rd_mux),
      .PC_MUX      (pc_mux),
      .DATA_MUX    (data_mux),
      .REG_GATE_B  (reg_gate_b),
      .REG_GATE_C  (reg_gate_c),
      .IR          (ir),
      .ALU_BUS     (alu_bus),
      .REG_COUNTER (reg_counter),
      .A_BUS       (a_bus),
      .B_BUS       (b_bus),
      .C_BUS       (c_bus),
      .ST          (st),
      .PC          (pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_ctl(input logic [9:0] c, input logic [31:0] ir_v, input logic [31:0] alu_v,
                          input logic d, input logic [31:0] bv);
      {rst, latch_reg, ir_rd_mux, lsm_rd_mux, rd_mux, pc_mux, data_mux, reg_gate_b,
       reg_gate_c} = c;
      ir      = ir_v;
      alu_bus = alu_v;
      drv_b   = d;
      b_val   = bv;
   endtask

   function automatic bit m_taken(input int idx);
      foreach (m_done[k]) begin
         if (m_done[k] == idx) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Lowest listed register of the current IR not yet transferred.
   function automatic int m_cnt();
      for (int i = 0; i < 16; i++) begin
         if (ir[i] && !m_taken(i)) return i;
      end
      return 0;
   endfunction

   function automatic bit m_pending();
      for (int i = 0; i < 16; i++) begin
         if (ir[i] && !m_taken(i)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Advance the model by one clock edge using the currently applied inputs.
   task automatic m_step();
      int          c;
      bit          p;
      int          widx;
      logic [31:0] wd;
      c = m_cnt();
      p = m_pending();
      if (rst) begin
         for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
         m_r[15] = START;
         m_done.delete();
      end else begin
         wd = data_mux ? b_val : alu_bus;
         case (rd_mux)
            2'd0:    widx = int'(ir[15:12]);
            2'd1:    widx = int'(ir[19:16]);
            2'd2:    widx = 14;
            default: widx = c;
         endcase
         if (pc_mux) m_r[15] = m_r[15] + 32'd4;
         if (latch_reg) m_r[widx] = wd;
         if (ir !== m_last_ir) begin
            m_done.delete();
         end else if (p && (lsm_rd_mux || (latch_reg && rd_mux == 2'd3))) begin
            m_done.push_back(c);
         end
      end
      m_last_ir = ir;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      set_ctl(C_RST, 32'h0, 32'h0, 1'b0, 32'h0);

      // ---------------- directed vector table ----------------
      vecs.push_back('{"reset", C_RST, 32'h0, 32'h0, 1'b0, 32'h0, 6'h00,
                       32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      for (int i = 0; i < 16; i++) begin
         vecs.push_back('{"reset_sweep", C_NONE, 32'(i) << 16, 32'h0, 1'b0, 32'h0,
                          M_A | M_PC | M_ST | M_CNT, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      end
      vecs.push_back('{"alu_wr", C_LATCH, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'h0,
                       M_PC | M_ST, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"a_rd", C_NONE, 32'h0003_0000, 32'h0, 1'b0, 32'h0,
                       M_A, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"b_rm", C_GB, 32'h0000_0003, 32'h0, 1'b0, 32'h0,
                       M_A | M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{"b_rd_idx", C_GB | C_IRRD, 32'h0000_3000, 32'h0, 1'b0, 32'h0,
                       M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{"b_released", C_NONE, 32'h0000_0003, 32'h0, 1'b1, 32'h5A5A_A5A5,
                       M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'h5A5A_A5A5, 32'h0});
      vecs.push_back('{"c_rs", C_GC, 32'h0000_0300, 32'h0, 1'b0, 32'h0,
                       M_C, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'hDEAD_BEEF});
      vecs.push_back('{"pc_inc0", C_PC, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_inc1", C_PC, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h4, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_inc2", C_PC, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h8, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_12", C_NONE, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'hC, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_override", C_PC | C_LATCH, 32'h0000_F000, 32'h100, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'hC, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_wrote", C_NONE, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h100, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_set_max", C_LATCH, 32'h0000_F000, 32'hFFFF_FFFC, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h100, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_wrap", C_PC, 32'h0, 32'h0, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'hFFFF_FFFC, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"pc_zero", C_NONE, 32'h000F_0000, 32'h0, 1'b0, 32'h0,
                       M_A | M_PC, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"link_wr", C_LATCH | C_RD10, 32'h0, 32'h44, 1'b0, 32'h0,
                       M_PC, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"link_rd", C_NONE, 32'h000E_0000, 32'h0, 1'b0, 32'h0,
                       M_A, 32'h44, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"bbus_wr", C_LATCH | C_RD01 | C_DATA, 32'h0005_0000, 32'h0BAD, 1'b1,
                       32'h1234, M_A, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"bbus_rd", C_NONE, 32'h0005_0000, 32'h0, 1'b0, 32'h0,
                       M_A, 32'h1234, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"sp_wr", C_LATCH, 32'h0000_D000, 32'h2000_0000, 1'b0, 32'h0,
                       M_ST, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"sp_rd", C_NONE, 32'h000D_0000, 32'h0, 1'b0, 32'h0,
                       M_A | M_ST, 32'h2000_0000, 32'h0, 32'h2000_0000, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"w_r1", C_LATCH, 32'h0000_1000, 32'h1111, 1'b0, 32'h0,
                       6'h00, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"w_r4", C_LATCH, 32'h0000_4000, 32'h4444, 1'b0, 32'h0,
                       6'h00, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"w_r15", C_LATCH, 32'h0000_F000, 32'h40, 1'b0, 32'h0,
                       6'h00, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"lsm_load", C_LSM | C_GB, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_PC | M_CNT | M_B, 32'h0, 32'h40, 32'h0, 4'd1, 32'h1111, 32'h0});
      vecs.push_back('{"lsm_r1", C_LSM | C_GB, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_PC | M_CNT | M_B, 32'h0, 32'h40, 32'h0, 4'd1, 32'h1111, 32'h0});
      vecs.push_back('{"lsm_r4", C_LSM | C_GB, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd4, 32'h4444, 32'h0});
      vecs.push_back('{"lsm_r15", C_LSM | C_GB, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_PC | M_CNT | M_B, 32'h0, 32'h40, 32'h0, 4'd15, 32'h40, 32'h0});
      vecs.push_back('{"lsm_empty", C_LSM | C_GB, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"lsm_9_load", C_LSM | C_GB, 32'h0000_0009, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"lsm_9_r0", C_LSM | C_GB, 32'h0000_0009, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"lsm_9_r3", C_LSM | C_GB, 32'h0000_0009, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd3, 32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{"lsm_9_end", C_LSM | C_GB, 32'h0000_0009, 32'h0, 1'b0, 32'h0,
                       M_CNT | M_B, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"lsm_30_load", C_NONE, 32'h0000_0030, 32'h0, 1'b0, 32'h0,
                       M_CNT, 32'h0, 32'h0, 32'h0, 4'd4, 32'h0, 32'h0});
      vecs.push_back('{"lsm_both", C_LSM | C_LATCH | C_RD11, 32'h0000_0030, 32'h5555, 1'b0,
                       32'h0, M_CNT, 32'h0, 32'h0, 32'h0, 4'd4, 32'h0, 32'h0});
      vecs.push_back('{"lsm_once", C_NONE, 32'h0000_0030, 32'h0, 1'b0, 32'h0,
                       M_CNT, 32'h0, 32'h0, 32'h0, 4'd5, 32'h0, 32'h0});
      vecs.push_back('{"r4_rd", C_NONE, 32'h0004_0000, 32'h0, 1'b0, 32'h0,
                       M_A, 32'h5555, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0});
      vecs.push_back('{"mid_load", C_LSM, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_PC | M_CNT, 32'h0, 32'h40, 32'h0, 4'd1, 32'h0, 32'h0});
      vecs.push_back('{"mid_step", C_LSM, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_CNT, 32'h0, 32'h0, 32'h0, 4'd1, 32'h0, 32'h0});
      vecs.push_back('{"mid_rst", C_RST | C_LSM, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_PC | M_ST | M_CNT, 32'h0, 32'h40, 32'h2000_0000, 4'd4, 32'h0, 32'h0});
      vecs.push_back('{"after_rst", C_NONE, 32'h0000_8012, 32'h0, 1'b0, 32'h0,
                       M_A | M_PC | M_ST | M_CNT, 32'h0, 32'h0, 32'h0, 4'd1, 32'h0, 32'h0});

      foreach (vecs[k]) begin
         @(negedge clk);
         set_ctl(vecs[k].ctl, vecs[k].ir, vecs[k].alu, vecs[k].drv, vecs[k].bval);
         #1;
         if (vecs[k].mask[0]) chk({vecs[k].name, "/A"}, a_bus, vecs[k].ea);
         if (vecs[k].mask[1]) chk({vecs[k].name, "/PC"}, pc, vecs[k].epc);
         if (vecs[k].mask[2]) chk({vecs[k].name, "/ST"}, st, vecs[k].est);
         if (vecs[k].mask[3]) chk({vecs[k].name, "/CNT"}, {28'h0, reg_counter},
                                  {28'h0, vecs[k].ecnt});
         if (vecs[k].mask[4]) chk({vecs[k].name, "/B"}, b_bus, vecs[k].eb);
         if (vecs[k].mask[5]) chk({vecs[k].name, "/C"}, c_bus, vecs[k].ec);
      end

      // ---------------- hand sequences ----------------
      // Same-cycle write is not bypassed to the read port.
      @(negedge clk);
      set_ctl(C_LATCH, 32'h0002_2000, 32'hCAFE_F00D, 1'b0, 32'h0);
      #1;
      chk("no_bypass", a_bus, 32'h0);
      @(negedge clk);
      set_ctl(C_GC, 32'h0002_0200, 32'h0, 1'b0, 32'h0);
      #1;
      chk("write_visible", a_bus, 32'hCAFE_F00D);
      chk("c_gated_on", c_bus, 32'hCAFE_F00D);
      @(negedge clk);
      set_ctl(C_NONE, 32'h0000_0200, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (c_bus === 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL c_gated_off: got %h expected not driven", c_bus);
      end
      // Illegal DATA_MUX=1 with REG_GATE_B=1: write captures the block's own B read.
      @(negedge clk);
      set_ctl(C_LATCH | C_DATA | C_GB, 32'h0000_6002, 32'h0BAD_0BAD, 1'b0, 32'h0);
      #1;
      chk("self_capture_b", b_bus, 32'hCAFE_F00D);
      @(negedge clk);
      set_ctl(C_NONE, 32'h0006_0000, 32'h0, 1'b0, 32'h0);
      #1;
      chk("self_capture_wr", a_bus, 32'hCAFE_F00D);

      // ---------------- randomized traffic vs. model ----------------
      m_last_ir = 32'h0;
      for (int n = 0; n < 800; n++) begin
         logic [3:0] bidx;
         @(negedge clk);
         rst        = (n == 0) || ($urandom_range(63) == 0);
         latch_reg  = 1'($urandom_range(1));
         ir_rd_mux  = 1'($urandom_range(1));
         lsm_rd_mux = 1'($urandom_range(1));
         rd_mux     = 2'($urandom_range(3));
         pc_mux     = ($urandom_range(3) == 0);
         data_mux   = ($urandom_range(3) == 0);
         reg_gate_b = data_mux ? 1'b0 : 1'($urandom_range(1));
         reg_gate_c = 1'($urandom_range(1));
         drv_b      = data_mux;
         b_val      = $urandom;
         alu_bus    = $urandom;
         if (n == 0 || $urandom_range(4) == 0) begin
            ir = $urandom;
            if ($urandom_range(1) == 1) ir[15:0] = ir[15:0] & 16'($urandom);
         end
         #1;
         if (n > 0) begin
            bidx = lsm_rd_mux ? 4'(m_cnt()) : (ir_rd_mux ? ir[15:12] : ir[3:0]);
            chk("rnd/A", a_bus, m_r[ir[19:16]]);
            chk("rnd/PC", pc, m_r[15]);
            chk("rnd/ST", st, m_r[13]);
            chk("rnd/CNT", {28'h0, reg_counter}, 32'(m_cnt()));
            if (reg_gate_b) chk("rnd/B", b_bus, m_r[bidx]);
            if (reg_gate_c) chk("rnd/C", c_bus, m_r[ir[11:8]]);
         end
         m_step();
      end

      @(negedge clk);
      drv_b = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
